// File: rtl/red_track_pkg.sv
// Shared definitions for the red-region frame controller: default widths,
// controller state encoding and the saturating drop-counter increment.
package red_track_pkg;

   localparam int unsigned XW_DEF = 10;
   localparam int unsigned YW_DEF = 10;
   localparam int unsigned CW_DEF = 19;
   localparam int unsigned DROP_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCUM  = 2'd1,
      ST_REPORT = 2'd2
   } state_t;

   function automatic logic [DROP_W-1:0] sat_inc_drop(input logic [DROP_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/red_bbox_accum.sv
// Per-frame hit counter and bounding-box registers. The next-state values are
// exported so the controller can capture a result that includes the current pixel.
module red_bbox_accum
   import red_track_pkg::*;
#(
   parameter int unsigned XW = XW_DEF,
   parameter int unsigned YW = YW_DEF,
   parameter int unsigned CW = CW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          init,
   input  logic          hit,
   input  logic [XW-1:0] x,
   input  logic [YW-1:0] y,
   output logic [CW-1:0] count_nxt,
   output logic [XW-1:0] x_min_nxt,
   output logic [XW-1:0] x_max_nxt,
   output logic [YW-1:0] y_min_nxt,
   output logic [YW-1:0] y_max_nxt
);

   logic [CW-1:0] count_q;
   logic [XW-1:0] x_min_q;
   logic [XW-1:0] x_max_q;
   logic [YW-1:0] y_min_q;
   logic [YW-1:0] y_max_q;

   // init selects the empty-frame values as the base, so a pixel arriving on
   // the init cycle becomes the first member of the new frame.
   always_comb begin
      count_nxt = init ? '0 : count_q;
      x_min_nxt = init ? '1 : x_min_q;
      x_max_nxt = init ? '0 : x_max_q;
      y_min_nxt = init ? '1 : y_min_q;
      y_max_nxt = init ? '0 : y_max_q;
      if (hit) begin
         if (count_nxt != '1) count_nxt = count_nxt + 1'b1;
         if (x < x_min_nxt)   x_min_nxt = x;
         if (x > x_max_nxt)   x_max_nxt = x;
         if (y < y_min_nxt)   y_min_nxt = y;
         if (y > y_max_nxt)   y_max_nxt = y;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         x_min_q <= '1;
         x_max_q <= '0;
         y_min_q <= '1;
         y_max_q <= '0;
      end else begin
         count_q <= count_nxt;
         x_min_q <= x_min_nxt;
         x_max_q <= x_max_nxt;
         y_min_q <= y_min_nxt;
         y_max_q <= y_max_nxt;
      end
   end

endmodule

// File: rtl/red_region_frame_ctrl.sv
// Frame controller: sequences accumulation per frame, registers one result per
// frame behind a valid/ready handshake and counts frames lost to back-pressure.
module red_region_frame_ctrl
   import red_track_pkg::*;
#(
   parameter int unsigned XW = XW_DEF,
   parameter int unsigned YW = YW_DEF,
   parameter int unsigned CW = CW_DEF
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic              iEN,
   input  logic              iSOF,
   input  logic              iEOF,
   input  logic              iDVAL,
   input  logic [XW-1:0]     iX,
   input  logic [YW-1:0]     iY,
   input  logic              iHIT,
   input  logic [CW-1:0]     iMIN_COUNT,
   output logic              oVALID,
   input  logic              iREADY,
   output logic              oFOUND,
   output logic [CW-1:0]     oCOUNT,
   output logic [XW-1:0]     oX_MIN,
   output logic [XW-1:0]     oX_MAX,
   output logic [YW-1:0]     oY_MIN,
   output logic [YW-1:0]     oY_MAX,
   output logic              oBUSY,
   output logic [DROP_W-1:0] oDROP_CNT
);

   state_t        state, state_nxt;
   logic [CW-1:0] min_q, min_eff, count_nxt;
   logic [XW-1:0] x_min_nxt, x_max_nxt;
   logic [YW-1:0] y_min_nxt, y_max_nxt;
   logic          accept, start_rep, restart, start, pix_hit, eof_cap, drop_inc, found_nxt;

   always_comb begin
      accept    = (state == ST_REPORT) & oVALID & iREADY;
      start_rep = accept & iSOF & iEN;
      restart   = (state == ST_ACCUM) & iSOF;
      start     = ((state == ST_IDLE) & iEN & iSOF) | start_rep | restart;
      pix_hit   = iDVAL & iHIT & (start | (state == ST_ACCUM));
      eof_cap   = iEOF & (start | (state == ST_ACCUM));
      drop_inc  = restart | ((state == ST_REPORT) & iSOF & ~accept);
      // A one-pixel frame compares against the minimum presented on its iSOF cycle.
      min_eff   = start ? iMIN_COUNT : min_q;
      found_nxt = (count_nxt >= min_eff);

      state_nxt = state;
      unique case (state)
         ST_IDLE:   if (start)   state_nxt = eof_cap ? ST_REPORT : ST_ACCUM;
         ST_ACCUM:  if (eof_cap) state_nxt = ST_REPORT;
         ST_REPORT: if (accept)  state_nxt = start ? (eof_cap ? ST_REPORT : ST_ACCUM) : ST_IDLE;
         default:                state_nxt = ST_IDLE;
      endcase
   end

   assign oBUSY = (state != ST_IDLE);

   red_bbox_accum #(.XW(XW), .YW(YW), .CW(CW)) u_accum (
      .clk       (iCLK),
      .rst       (iRST),
      .init      (start),
      .hit       (pix_hit),
      .x         (iX),
      .y         (iY),
      .count_nxt (count_nxt),
      .x_min_nxt (x_min_nxt),
      .x_max_nxt (x_max_nxt),
      .y_min_nxt (y_min_nxt),
      .y_max_nxt (y_max_nxt)
   );

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state     <= ST_IDLE;
         oVALID    <= 1'b0;
         oFOUND    <= 1'b0;
         oCOUNT    <= '0;
         oX_MIN    <= '0;
         oX_MAX    <= '0;
         oY_MIN    <= '0;
         oY_MAX    <= '0;
         oDROP_CNT <= '0;
         min_q     <= '0;
      end else begin
         state  <= state_nxt;
         oVALID <= (state_nxt == ST_REPORT);
         if (start) min_q <= iMIN_COUNT;
         if (eof_cap) begin
            oFOUND <= found_nxt;
            oCOUNT <= count_nxt;
            oX_MIN <= found_nxt ? x_min_nxt : '0;
            oX_MAX <= found_nxt ? x_max_nxt : '0;
            oY_MIN <= found_nxt ? y_min_nxt : '0;
            oY_MAX <= found_nxt ? y_max_nxt : '0;
         end
         if (drop_inc) oDROP_CNT <= sat_inc_drop(oDROP_CNT);
      end
   end

endmodule

// File: tb/tb_red_region_frame_ctrl.sv
// Directed and randomized bench for red_region_frame_ctrl, checked against a
// list-based frame model (hits collected per frame, result computed at EOF).
module tb_red_region_frame_ctrl;

   localparam int XW   = 10;
   localparam int YW   = 10;
   // Narrow counter so saturation is reachable in a short run.
   localparam int CW   = 10;
   localparam int CMAX = (1 << CW) - 1;

   logic          iCLK, iRST, iEN, iSOF, iEOF, iDVAL, iHIT, iREADY;
   logic [XW-1:0] iX;
   logic [YW-1:0] iY;
   logic [CW-1:0] iMIN_COUNT;
   logic          oVALID, oFOUND, oBUSY;
   logic [CW-1:0] oCOUNT;
   logic [XW-1:0] oX_MIN, oX_MAX;
   logic [YW-1:0] oY_MIN, oY_MAX;
   logic [7:0]    oDROP_CNT;

   red_region_frame_ctrl #(.XW(XW), .YW(YW), .CW(CW)) dut (
      .iCLK(iCLK), .iRST(iRST), .iEN(iEN), .iSOF(iSOF), .iEOF(iEOF),
      .iDVAL(iDVAL), .iX(iX), .iY(iY), .iHIT(iHIT), .iMIN_COUNT(iMIN_COUNT),
      .oVALID(oVALID), .iREADY(iREADY), .oFOUND(oFOUND), .oCOUNT(oCOUNT),
      .oX_MIN(oX_MIN), .oX_MAX(oX_MAX), .oY_MIN(oY_MIN), .oY_MAX(oY_MAX),
      .oBUSY(oBUSY), .oDROP_CNT(oDROP_CNT)
   );

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   int tests = 0;
   int fails = 0;

   // Model: mode 0 = no frame, 1 = frame open, 2 = result pending.
   int mode = 0;
   int hx[$], hy[$];
   int m_min = 0, m_drop = 0;
   int r_cnt = 0, r_found = 0, r_x0 = 0, r_x1 = 0, r_y0 = 0, r_y1 = 0;

   int fq_x[$], fq_y[$], fq_h[$], fq_d[$], fq_s[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic open_frame();
      mode = 1;
      hx.delete();
      hy.delete();
      m_min = int'(iMIN_COUNT);
   endtask

   task automatic model_step();
      if (iRST) begin
         mode = 0; m_drop = 0;
         hx.delete(); hy.delete();
      end else begin
         if (mode == 2 && iREADY) begin
            mode = 0;
            if (iSOF && iEN) open_frame();
         end else if (mode == 2 && iSOF) begin
            if (m_drop < 255) m_drop++;
         end else if (mode == 1 && iSOF) begin
            if (m_drop < 255) m_drop++;
            open_frame();
         end else if (mode == 0 && iSOF && iEN) begin
            open_frame();
         end
         if (mode == 1 && iDVAL && iHIT) begin
            hx.push_back(int'(iX));
            hy.push_back(int'(iY));
         end
         if (mode == 1 && iEOF) begin
            r_cnt   = (hx.size() > CMAX) ? CMAX : hx.size();
            r_found = (r_cnt >= m_min);
            r_x0 = (1 << XW) - 1; r_x1 = 0; r_y0 = (1 << YW) - 1; r_y1 = 0;
            foreach (hx[i]) begin
               if (hx[i] < r_x0) r_x0 = hx[i];
               if (hx[i] > r_x1) r_x1 = hx[i];
               if (hy[i] < r_y0) r_y0 = hy[i];
               if (hy[i] > r_y1) r_y1 = hy[i];
            end
            if (!r_found) begin r_x0 = 0; r_x1 = 0; r_y0 = 0; r_y1 = 0; end
            mode = 2;
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge iCLK);
      #1;
      chk("busy",  oBUSY,  mode != 0);
      chk("valid", oVALID, mode == 2);
      chk("drop",  oDROP_CNT, m_drop);
      if (mode == 2) begin
         chk("found", oFOUND, r_found);
         chk("count", oCOUNT, r_cnt);
         chk("x_min", oX_MIN, r_x0);
         chk("x_max", oX_MAX, r_x1);
         chk("y_min", oY_MIN, r_y0);
         chk("y_max", oY_MAX, r_y1);
      end
   endtask

   task automatic px(input bit s, input bit e, input bit d, input bit h, input int x, input int y);
      iSOF = s; iEOF = e; iDVAL = d; iHIT = h;
      iX = XW'(x); iY = YW'(y);
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) px(0, 0, 0, 0, 0, 0);
   endtask

   task automatic add_px(input int x, input int y, input bit h);
      fq_x.push_back(x); fq_y.push_back(y); fq_h.push_back(h);
      fq_d.push_back(1); fq_s.push_back(0);
   endtask

   // Sends the queued pixels as one frame; iREADY is driven only on the iSOF cycle.
   task automatic send_frame(input bit rdy_sof);
      int last;
      last = fq_x.size() - 1;
      for (int i = 0; i <= last; i++) begin
         iREADY = (i == 0) ? rdy_sof : 1'b0;
         px((i == 0) || (fq_s[i] != 0), i == last, fq_d[i] != 0, fq_h[i] != 0, fq_x[i], fq_y[i]);
      end
      iREADY = 1'b0;
      fq_x.delete(); fq_y.delete(); fq_h.delete(); fq_d.delete(); fq_s.delete();
   endtask

   task automatic frame_abc();
      add_px(10, 10, 0);  add_px(100, 50, 1); add_px(20, 30, 0);
      add_px(200, 80, 1); add_px(150, 60, 1); add_px(5, 5, 0);
   endtask

   task automatic accept();
      iREADY = 1'b1;
      px(0, 0, 0, 0, 0, 0);
      iREADY = 1'b0;
   endtask

   initial begin
      int act;
      bit ovl;
      iRST = 1; iEN = 0; iSOF = 0; iEOF = 0; iDVAL = 0; iHIT = 0;
      iREADY = 0; iX = '0; iY = '0; iMIN_COUNT = '0;
      tick();
      chk("rst_valid", oVALID, 0); chk("rst_busy", oBUSY, 0);
      chk("rst_found", oFOUND, 0); chk("rst_count", oCOUNT, 0);
      chk("rst_xmin", oX_MIN, 0);  chk("rst_xmax", oX_MAX, 0);
      chk("rst_ymin", oY_MIN, 0);  chk("rst_ymax", oY_MAX, 0);
      chk("rst_drop", oDROP_CNT, 0);
      iRST = 0; iEN = 1;
      idle(2);

      // Three hits, min 2
      iMIN_COUNT = 2; frame_abc(); send_frame(0);
      chk("t1_valid", oVALID, 1); chk("t1_found", oFOUND, 1); chk("t1_count", oCOUNT, 3);
      chk("t1_xmin", oX_MIN, 100); chk("t1_xmax", oX_MAX, 200);
      chk("t1_ymin", oY_MIN, 50);  chk("t1_ymax", oY_MAX, 80);
      idle(3); accept();

      // Same frame, min 4
      iMIN_COUNT = 4; frame_abc(); send_frame(0);
      chk("t2_found", oFOUND, 0); chk("t2_count", oCOUNT, 3);
      chk("t2_xmin", oX_MIN, 0); chk("t2_xmax", oX_MAX, 0);
      chk("t2_ymin", oY_MIN, 0); chk("t2_ymax", oY_MAX, 0);
      accept();

      // Result held while a later frame is dropped
      iMIN_COUNT = 2; frame_abc(); send_frame(0);
      iMIN_COUNT = 1; add_px(1, 1, 1); add_px(2, 2, 1); send_frame(0);
      chk("t3_drop", oDROP_CNT, 1); chk("t3_count", oCOUNT, 3); chk("t3_xmax", oX_MAX, 200);
      accept();
      chk("t3_busy", oBUSY, 0);

      // Accept coinciding with the next iSOF
      iMIN_COUNT = 2; frame_abc(); send_frame(0);
      add_px(30, 40, 1); add_px(31, 41, 0); add_px(35, 45, 1); send_frame(1);
      chk("t4_drop", oDROP_CNT, 1); chk("t4_count", oCOUNT, 2); chk("t4_xmin", oX_MIN, 30);
      accept();

      // Reset mid-frame discards accumulated hits
      iMIN_COUNT = 1;
      px(1, 0, 1, 1, 400, 300);
      for (int i = 0; i < 4; i++) px(0, 0, 1, 1, 410 + i, 310);
      iRST = 1; px(0, 0, 0, 0, 0, 0); iRST = 0;
      chk("t5_busy", oBUSY, 0); chk("t5_valid", oVALID, 0);
      add_px(300, 100, 1); add_px(0, 0, 0); send_frame(0);
      chk("t5_count", oCOUNT, 1); chk("t5_xmin", oX_MIN, 300); chk("t5_ymax", oY_MAX, 100);
      accept();

      // One-pixel frame
      px(1, 1, 1, 1, 7, 9);
      chk("one_valid", oVALID, 1); chk("one_count", oCOUNT, 1); chk("one_xmin", oX_MIN, 7);
      accept();

      // Enable dropped mid-frame: frame completes, next iSOF ignored
      px(1, 0, 1, 1, 50, 60); iEN = 0;
      px(0, 0, 1, 1, 70, 80); px(0, 1, 1, 0, 90, 90);
      chk("en_valid", oVALID, 1); chk("en_count", oCOUNT, 2);
      accept();
      px(1, 0, 1, 1, 5, 5); idle(1);
      chk("en_idle", oBUSY, 0);
      iEN = 1;

      // Extreme corners plus count saturation
      iMIN_COUNT = 2;
      px(1, 0, 1, 1, 0, 0);
      for (int i = 0; i < CMAX + 80; i++) px(0, 0, 1, 1, 320, 240);
      px(0, 1, 1, 1, 639, 479);
      chk("sat_count", oCOUNT, CMAX); chk("sat_found", oFOUND, 1);
      chk("sat_xmin", oX_MIN, 0); chk("sat_xmax", oX_MAX, 639);
      chk("sat_ymin", oY_MIN, 0); chk("sat_ymax", oY_MAX, 479);
      accept();

      // Randomized frames with mixed hand-off timing
      ovl = 0;
      for (int f = 0; f < 60; f++) begin
         iMIN_COUNT = CW'($urandom_range(0, 8));
         for (int p = 0; p < int'($urandom_range(1, 30)); p++) begin
            add_px($urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 9) < 3);
            fq_d[p] = ($urandom_range(0, 9) != 0);
            fq_s[p] = (p > 0) && ($urandom_range(0, 24) == 0);
         end
         send_frame(ovl);
         ovl = 0;
         act = $urandom_range(0, 3);
         case (act)
            0: accept();
            1: begin
               for (int k = 0; k < int'($urandom_range(0, 3)); k++) px(0, 0, 0, 0, 0, 0);
               accept();
            end
            2: ovl = 1;
            default: begin
               add_px(1, 2, 1); add_px(3, 4, 1); send_frame(0);
               accept();
               iREADY = 1'(($urandom_range(0, 1)));
               px(0, 0, 0, 0, 0, 0);
               iREADY = 0;
            end
         endcase
      end
      if (ovl) accept();

      // Drop counter saturation
      add_px(9, 9, 1); send_frame(0);
      for (int i = 0; i < 260; i++) px(1, 0, 1, 1, 1, 1);
      chk("drop_sat", oDROP_CNT, 255);
      accept();
      idle(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
